flex_down_timer: RTL

Loadable, parameterised down-counting timer with one-shot and periodic (auto-reload) modes. It complements the up-counting rollover counters used across the design: it counts enabled cycles down from a loaded value and flags expiry. Typical uses are bit-period timing, timeouts and transmit pacing. The timer sits beside the control FSMs, which load it and react to its `expire` pulse.

---
 rtl/flex_timer_pkg.sv | 19 +
 rtl/flex_down_timer.sv | 113 +++++++++++
 2 files changed

// File: rtl/flex_timer_pkg.sv
// -----------------------------------------------------------------------------
// flex_timer_pkg
// Shared types and constants for the flex_down_timer block and the control
// FSMs that drive it.
//   timer_state_t : IDLE (stopped) / RUN (counting down)
//   MODE_ONESHOT  : stop in IDLE after the count reaches zero
//   MODE_PERIODIC : reload from the reload register and keep running
// -----------------------------------------------------------------------------
package flex_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : flex_timer_pkg

// File: rtl/flex_down_timer.sv
// -----------------------------------------------------------------------------
// flex_down_timer
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// It counts enabled cycles down from a loaded value and pulses `expire` for one
// cycle when a period completes.
//
// Parameters
//   NUM_CNT_BITS : width of the count, load value and reload register
// Ports
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   clear        in   synchronous abort: zero count/reload, go IDLE
//   load         in   synchronous start/restart from load_val
//   load_val     in   start value, sampled with load
//   mode         in   0 = one-shot, 1 = periodic, sampled with load
//   count_enable in   decrement qualifier, only honoured in RUN
//   count_out    out  current count (registered)
//   expire       out  one-cycle registered pulse at the end of a period
//   busy         out  high while in RUN (registered)
// Priority per cycle: clear > load > count_enable.
// -----------------------------------------------------------------------------
module flex_down_timer
    import flex_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    mode,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire,
    output logic                    busy
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    timer_state_t            state_q,  state_d;
    logic [NUM_CNT_BITS-1:0] count_q,  count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    mode_q,   mode_d;
    logic                    expire_q, expire_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            mode_q   <= MODE_ONESHOT;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            count_d  = CNT_ZERO;
            reload_d = CNT_ZERO;
        end else if (load) begin
            if (load_val != CNT_ZERO) begin
                state_d  = RUN;
                count_d  = load_val;
                reload_d = load_val;
                mode_d   = mode;
            end else begin
                // A zero-length period is treated as "stop": nothing to time.
                state_d  = IDLE;
                count_d  = CNT_ZERO;
                reload_d = CNT_ZERO;
            end
        end else if ((state_q == RUN) && count_enable) begin
            if (count_q > CNT_ONE) begin
                count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
                expire_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    // Reloading at 1 (not 0) makes a period exactly `reload`
                    // enabled cycles.
                    count_d = reload_q;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = IDLE;
                end
            end else begin
                // RUN with a zero count is unreachable; fall back to IDLE
                // rather than wrapping.
                state_d = IDLE;
            end
        end
    end

    assign count_out = count_q;
    assign expire    = expire_q;
    // The state enum is one bit wide, so this is the state flop itself.
    assign busy      = (state_q == RUN);

endmodule : flex_down_timer
